// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter fed by a push-on-rising-edge byte queue.
//            Define UART_TX_FIFO_EN for a 4-entry FIFO; otherwise a single
//            holding register is used.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd868,
  parameter logic [3:0]  DATA_BITS    = 4'd8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       uart_te,
  input  logic [7:0] uart_txd,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam logic [15:0] BAUD_LAST = CLKS_PER_BIT - 16'd1;
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 4'd1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        te_q;
  logic        overflow_q;

  logic        push_w;
  logic        push_ok_w;
  logic        pop_w;
  logic        baud_end_w;
  logic        q_avail_w;
  logic        q_busy_w;
  logic [7:0]  q_head_w;

  assign push_w     = uart_te & ~te_q;
  assign baud_end_w = (baud_q == BAUD_LAST);

`ifdef UART_TX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;

  // A full queue refuses the push even when a pop frees a slot this cycle.
  assign push_ok_w = push_w & (count_q != 3'd4);
  assign q_avail_w = (count_q != 3'd0);
  assign q_busy_w  = (count_q != 3'd0);
  assign q_head_w  = mem_q[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push_ok_w) begin
        mem_q[wr_ptr_q] <= uart_txd;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      case ({push_ok_w, pop_w})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic [7:0] hold_q;
  logic       full_q;
  logic       pend_q;
  logic       frame_done_w;

  // The single entry stays occupied until its frame has fully left the line,
  // so a push during transmission is dropped rather than queued.
  assign frame_done_w = (state_q == S_STOP) & baud_end_w;
  assign push_ok_w    = push_w & ~full_q;
  assign q_avail_w    = pend_q;
  assign q_busy_w     = full_q;
  assign q_head_w     = hold_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_q <= 8'd0;
      full_q <= 1'b0;
      pend_q <= 1'b0;
    end else if (push_ok_w) begin
      hold_q <= uart_txd;
      full_q <= 1'b1;
      pend_q <= 1'b1;
    end else begin
      if (pop_w) begin
        pend_q <= 1'b0;
      end
      if (frame_done_w) begin
        full_q <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      te_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      te_q       <= uart_te;
      overflow_q <= overflow_q | (push_w & ~push_ok_w);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is derived from the state being entered so the line is registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop_w   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = 16'd0;
        bit_d  = 3'd0;
        if (q_avail_w) begin
          pop_w   = 1'b1;
          shreg_d = q_head_w;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_end_w) begin
          baud_d  = 16'd0;
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end_w) begin
          baud_d = 16'd0;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_end_w) begin
          baud_d  = 16'd0;
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx       = tx_q;
  assign busy     = (state_q != S_IDLE) | q_busy_w;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Scoreboard bench for uart_tx at CLKS_PER_BIT=4; a line monitor
//            decodes frames and compares against queued expected bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam logic [15:0] CPB = 16'd4;

  logic       CLK      = 1'b0;
  logic       RST      = 1'b1;
  logic       uart_te  = 1'b0;
  logic [7:0] uart_txd = 8'd0;
  logic       tx;
  logic       busy;
  logic       overflow;

  int         n_cmp  = 0;
  int         n_err  = 0;
  int         cyc    = 0;
  int         frames = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (4'd8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .uart_te  (uart_te),
    .uart_txd (uart_txd),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives one rising edge of uart_te; the byte is expected on the line only if sent=1.
  task automatic push_byte(input logic [7:0] b, input bit sent);
    @(posedge CLK);
    #1;
    uart_txd = b;
    uart_te  = 1'b1;
    if (sent) exp_q.push_back(b);
    @(posedge CLK);
    #1;
    uart_te = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      @(negedge CLK);
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  // Line monitor: samples each bit in its middle (offset 2 of 4) and aborts on reset.
  initial begin : monitor
    logic [9:0] bits;
    logic [7:0] e;
    bit         aborted;
    forever begin
      @(negedge CLK);
      if (RST === 1'b0 && tx === 1'b0) begin
        start_q.push_back(cyc);
        aborted = 1'b0;
        bits    = '1;
        for (int o = 1; o < 40; o++) begin
          @(negedge CLK);
          if (RST === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (o % 4 == 2) bits[4'(o / 4)] = tx;
        end
        if (!aborted) begin
          frames++;
          check("start_bit", 32'(bits[0]), 32'd0);
          check("stop_bit", 32'(bits[9]), 32'd1);
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_data", 32'(bits[8:1]), 32'(e));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] v;
    int         f0;
    int         k;
    logic       eb;

    // Reset, with uart_te already high so the first free cycle is a push.
    uart_te  = 1'b1;
    uart_txd = 8'hE7;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    RST = 1'b0;
    exp_q.push_back(8'hE7);
    @(posedge CLK);
    #1;
    uart_te = 1'b0;
    @(negedge CLK);
    check("post_rst_push_busy", 32'(busy), 32'd1);
    wait_idle(200);

    // Single byte: exact line waveform and busy fall time.
    v = 8'h55;
    push_byte(v, 1'b1);
    @(negedge CLK);
    check("single_pre_tx", 32'(tx), 32'd1);
    check("single_pre_busy", 32'(busy), 32'd1);
    for (int j = 0; j < 40; j++) begin
      @(negedge CLK);
      if (j < 4) eb = 1'b0;
      else if (j < 36) begin
        k  = (j - 4) / 4;
        eb = v[3'(k)];
      end else eb = 1'b1;
      check("single_tx", 32'(tx), 32'(eb));
    end
    check("single_busy_last", 32'(busy), 32'd1);
    @(negedge CLK);
    check("single_busy_fall", 32'(busy), 32'd0);
    check("single_tx_idle", 32'(tx), 32'd1);
    wait_idle(50);

`ifdef UART_TX_FIFO_EN
    // Burst of four: in order, 41-cycle period, no overflow.
    start_q.delete();
    push_byte(8'hA1, 1'b1);
    push_byte(8'hB2, 1'b1);
    push_byte(8'hC3, 1'b1);
    push_byte(8'hD4, 1'b1);
    wait_idle(400);
    check("burst_frames", 32'(start_q.size()), 32'd4);
    for (int i = 1; i < start_q.size(); i++)
      check("burst_period", 32'(start_q[i] - start_q[i-1]), 32'd41);
    check("burst_overflow", 32'(overflow), 32'd0);
`endif

    // Held level: one push only.
    f0 = frames;
    @(posedge CLK);
    #1;
    uart_txd = 8'h3C;
    uart_te  = 1'b1;
    exp_q.push_back(8'h3C);
    repeat (100) @(posedge CLK);
    #1;
    uart_te = 1'b0;
    wait_idle(300);
    check("held_frames", 32'(frames - f0), 32'd1);

`ifdef UART_TX_FIFO_EN
    // Six pushes during the first frame: the sixth finds the FIFO full.
    for (int i = 0; i < 6; i++) push_byte(8'(8'h10 + i), (i < 5));
    check("ovf_set", 32'(overflow), 32'd1);
    wait_idle(600);
    check("ovf_sticky", 32'(overflow), 32'd1);
`else
    // Second push lands while the holding register is still in service.
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b0);
    check("hold_ovf_set", 32'(overflow), 32'd1);
    wait_idle(200);
    check("hold_ovf_sticky", 32'(overflow), 32'd1);
`endif

    // Reset during DATA bit 3 aborts the frame and clears everything.
    f0 = frames;
    v  = 8'h96;
    push_byte(v, 1'b0);
    repeat (17) @(posedge CLK);
    #1;
    check("mid_bit3_tx", 32'(tx), 32'(v[3]));
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    RST = 1'b0;
    repeat (60) @(negedge CLK);
    check("mid_no_frame", 32'(frames - f0), 32'd0);
    check("mid_idle_busy", 32'(busy), 32'd0);
    check("mid_idle_tx", 32'(tx), 32'd1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
